// File: rtl/sar_pkg.sv
// Shared types and constants for the signed successive-approximation search.
package sar_pkg;

    localparam int SAR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TEST   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

endpackage

// File: rtl/signed_sar_search.sv
// Signed SAR search against an external combinational comparator (offset-binary domain, MSB first).
// Optional macro SAR_EARLY_EXIT_EN: an exact match during TEST finishes the search immediately.
module signed_sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    cmp_gt,
    input  logic                    cmp_eq,
    input  logic                    cmp_lt,
    output logic signed [WIDTH-1:0] trial,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result,
    output logic                    exact,
    output logic                    flag_err
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [KW-1:0]    K_TOP    = KW'(WIDTH - 1);

    sar_state_t                state_reg, state_next;
    logic [WIDTH-1:0]          u_reg, u_next, u_step;
    logic [KW-1:0]             k_reg, k_next;
    logic signed [WIDTH-1:0]   result_reg, result_next;
    logic                      exact_reg, exact_next;
    logic                      err_reg, err_next;
    logic                      flags_ok;
    logic                      keep_bit;

    // Offset domain u maps the signed code onto an unsigned ladder.
    assign trial    = $signed(u_reg ^ MSB_MASK);
    assign busy     = (state_reg == TEST) || (state_reg == VERIFY);
    assign done     = (state_reg == DONE);
    assign result   = result_reg;
    assign exact    = exact_reg;
    assign flag_err = err_reg;

    assign flags_ok = $onehot({cmp_gt, cmp_eq, cmp_lt});
    // Malformed flags resolve as "target below trial".
    assign keep_bit = flags_ok && (cmp_gt || cmp_eq);

    always_comb begin
        state_next  = state_reg;
        u_next      = u_reg;
        k_next      = k_reg;
        result_next = result_reg;
        exact_next  = exact_reg;
        err_next    = err_reg;
        u_step      = u_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    u_next     = MSB_MASK;
                    k_next     = K_TOP;
                    err_next   = 1'b0;
                    state_next = TEST;
                end
            end
            TEST: begin
                if (!flags_ok) begin
                    err_next = 1'b1;
                end
`ifdef SAR_EARLY_EXIT_EN
                if (flags_ok && cmp_eq) begin
                    result_next = trial;
                    exact_next  = 1'b1;
                    state_next  = DONE;
                end else
`endif
                begin
                    if (!keep_bit) begin
                        u_step[k_reg] = 1'b0;
                    end
                    if (k_reg != '0) begin
                        u_step[k_reg - KW'(1)] = 1'b1;
                        k_next = k_reg - KW'(1);
                    end else begin
                        state_next = VERIFY;
                    end
                    u_next = u_step;
                end
            end
            VERIFY: begin
                result_next = trial;
                exact_next  = cmp_eq;
                state_next  = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            u_reg      <= MSB_MASK;
            k_reg      <= K_TOP;
            result_reg <= '0;
            exact_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            u_reg      <= u_next;
            k_reg      <= k_next;
            result_reg <= result_next;
            exact_reg  <= exact_next;
            err_reg    <= err_next;
        end
    end

endmodule
